// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encodings,
// default MUL/DIV latency, hazard-cause encoding and the cause-to-control table.
package hazard_ctrl_pkg;

   localparam logic [0:0] HZ_IDLE = 1'b0;
   localparam logic [0:0] HZ_BUSY = 1'b1;

   localparam int MD_LAT_DEFAULT = 4;

   typedef enum logic [1:0] {
      HZ_CAUSE_NONE = 2'd0,
      HZ_CAUSE_LU   = 2'd1,
      HZ_CAUSE_BR   = 2'd2,
      HZ_CAUSE_MD   = 2'd3
   } hz_cause_e;

   typedef struct packed {
      logic pc_write;
      logic ifid_write;
      logic idex_write;
      logic ifid_flush;
      logic idex_flush;
      logic exmem_bubble;
   } hz_ctrl_t;

   // One row per hazard cause; the winning cause alone decides every control.
   function automatic hz_ctrl_t cause_to_ctrl(input hz_cause_e cause);
      hz_ctrl_t ctrl;
      ctrl = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      case (cause)
         HZ_CAUSE_MD:   ctrl = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
         HZ_CAUSE_BR:   ctrl = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
         HZ_CAUSE_LU:   ctrl = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
         default:       ctrl = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      endcase
      return ctrl;
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// ID/EX hazard inputs and pipeline control outputs of the hazard controller.
// The pipeline side uses the master modport, hazard_ctrl uses slave.
interface hazard_ctrl_if;

   logic [4:0] ID_rs1;
   logic [4:0] ID_rs2;
   logic       ID_use_rs1;
   logic       ID_use_rs2;
   logic [4:0] EX_RdAddr;
   logic       EX_MemRead;
   logic       EX_RegWrite;
   logic       EX_md_start;
   logic       EX_branch_taken;

   logic       PC_write;
   logic       IFID_write;
   logic       IDEX_write;
   logic       IFID_flush;
   logic       IDEX_flush;
   logic       EXMEM_bubble;

   modport master (
      output ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2,
             EX_RdAddr, EX_MemRead, EX_RegWrite, EX_md_start, EX_branch_taken,
      input  PC_write, IFID_write, IDEX_write, IFID_flush, IDEX_flush, EXMEM_bubble
   );

   modport slave (
      input  ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2,
             EX_RdAddr, EX_MemRead, EX_RegWrite, EX_md_start, EX_branch_taken,
      output PC_write, IFID_write, IDEX_write, IFID_flush, IDEX_flush, EXMEM_bubble
   );

endinterface

// File: rtl/hazard_ctrl_md_busy_fsm.sv
// MUL/DIV occupancy tracker: holds the pipeline for MD_LAT-1 cycles after a
// MUL/DIV reaches EX, then releases for exactly one cycle before re-arming.
module md_busy_fsm
   import hazard_ctrl_pkg::*;
#(
   parameter int MD_LAT = MD_LAT_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic md_start,
   output logic hold
);

   localparam logic       MULTI = (MD_LAT > 1);
   localparam logic [3:0] LOAD  = MULTI ? 4'(MD_LAT - 2) : 4'd0;

   logic [0:0] r_state;
   logic [3:0] r_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= HZ_IDLE;
         r_cnt   <= 4'd0;
      end else begin
         case (r_state)
            HZ_IDLE: begin
               if (md_start && MULTI) begin
                  r_state <= HZ_BUSY;
                  r_cnt   <= LOAD;
               end
            end
            HZ_BUSY: begin
               if (r_cnt != 4'd0) r_cnt   <= r_cnt - 4'd1;
               else               r_state <= HZ_IDLE;
            end
            default: begin
               r_state <= HZ_IDLE;
               r_cnt   <= 4'd0;
            end
         endcase
      end
   end

   // md_start is a level, so in BUSY it is deliberately ignored.
   always_comb begin
      hold = 1'b0;
      case (r_state)
         HZ_IDLE: hold = md_start && MULTI;
         HZ_BUSY: hold = (r_cnt != 4'd0);
         default: hold = 1'b0;
      endcase
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch flush and MUL/DIV hold.
// Optional stall cycle counter enabled by macro HAZARD_STALL_CNT_EN.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int MD_LAT = MD_LAT_DEFAULT
`ifdef HAZARD_STALL_CNT_EN
   ,
   parameter int CNT_W  = 32
`endif
) (
   input  logic             clk,
   input  logic             rst,
   hazard_ctrl_if.slave     hz
`ifdef HAZARD_STALL_CNT_EN
   ,
   output logic [CNT_W-1:0] stall_cnt
`endif
);

   logic      w_hold;
   logic      w_lu;
   hz_cause_e w_cause;
   hz_ctrl_t  w_ctrl;

   md_busy_fsm #(
      .MD_LAT   (MD_LAT)
   ) u_md_busy_fsm (
      .clk      (clk),
      .rst      (rst),
      .md_start (hz.EX_md_start),
      .hold     (w_hold)
   );

   assign w_lu = hz.EX_MemRead && hz.EX_RegWrite && (hz.EX_RdAddr != 5'd0) &&
                 ((hz.ID_use_rs1 && (hz.ID_rs1 == hz.EX_RdAddr)) ||
                  (hz.ID_use_rs2 && (hz.ID_rs2 == hz.EX_RdAddr)));

   // A taken branch discards the ID instruction, so it outranks a load-use stall.
   always_comb begin
      w_cause = HZ_CAUSE_NONE;
      if (w_hold)                  w_cause = HZ_CAUSE_MD;
      else if (hz.EX_branch_taken) w_cause = HZ_CAUSE_BR;
      else if (w_lu)               w_cause = HZ_CAUSE_LU;
   end

   assign w_ctrl          = cause_to_ctrl(w_cause);
   assign hz.PC_write     = w_ctrl.pc_write;
   assign hz.IFID_write   = w_ctrl.ifid_write;
   assign hz.IDEX_write   = w_ctrl.idex_write;
   assign hz.IFID_flush   = w_ctrl.ifid_flush;
   assign hz.IDEX_flush   = w_ctrl.idex_flush;
   assign hz.EXMEM_bubble = w_ctrl.exmem_bubble;

`ifdef HAZARD_STALL_CNT_EN
   logic [CNT_W-1:0] r_stall_cnt;

   // Counts frozen-PC cycles only; branch flushes keep PC moving and are skipped.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stall_cnt <= '0;
      end else if (!w_ctrl.pc_write && (r_stall_cnt != '1)) begin
         r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: MD_LAT=4 instance (CNT_W=4 when counting)
// and an MD_LAT=1 instance driven by the same directed vectors.
module tb_hazard_ctrl;
   import hazard_ctrl_pkg::*;

   logic clk;
   logic rst;

   hazard_ctrl_if hz();
   hazard_ctrl_if hz1();

   assign hz1.ID_rs1          = hz.ID_rs1;
   assign hz1.ID_rs2          = hz.ID_rs2;
   assign hz1.ID_use_rs1      = hz.ID_use_rs1;
   assign hz1.ID_use_rs2      = hz.ID_use_rs2;
   assign hz1.EX_RdAddr       = hz.EX_RdAddr;
   assign hz1.EX_MemRead      = hz.EX_MemRead;
   assign hz1.EX_RegWrite     = hz.EX_RegWrite;
   assign hz1.EX_md_start     = hz.EX_md_start;
   assign hz1.EX_branch_taken = hz.EX_branch_taken;

`ifdef HAZARD_STALL_CNT_EN
   logic [3:0]  stallCnt4;
   logic [31:0] stallCnt1;

   hazard_ctrl #(.MD_LAT(4), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .hz(hz), .stall_cnt(stallCnt4)
   );
   hazard_ctrl #(.MD_LAT(1), .CNT_W(32)) dut1 (
      .clk(clk), .rst(rst), .hz(hz1), .stall_cnt(stallCnt1)
   );
`else
   hazard_ctrl #(.MD_LAT(4)) dut (
      .clk(clk), .rst(rst), .hz(hz)
   );
   hazard_ctrl #(.MD_LAT(1)) dut1 (
      .clk(clk), .rst(rst), .hz(hz1)
   );
`endif

   typedef struct {
      int          idx;
      logic [5:0]  ctrl4;
      logic [5:0]  ctrl1;
      logic [3:0]  cnt4;
      logic [31:0] cnt1;
   } exp_t;

   exp_t        sb[$];
   int          total;
   int          bad;
   int          vecIdx;
   logic [3:0]  modelCnt4;
   logic [31:0] modelCnt1;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bit order: PC_write, IFID_write, IDEX_write, IFID_flush, IDEX_flush, EXMEM_bubble.
   function automatic logic [5:0] expCtrl(input hz_cause_e c);
      case (c)
         HZ_CAUSE_LU: return 6'b001010;
         HZ_CAUSE_BR: return 6'b111110;
         HZ_CAUSE_MD: return 6'b000001;
         default:     return 6'b111000;
      endcase
   endfunction

   task automatic applyStimulus(
      input logic       r,
      input logic [4:0] rs1, input logic [4:0] rs2,
      input logic       u1,  input logic       u2,
      input logic [4:0] rd,
      input logic       mr,  input logic       rw,
      input logic       md,  input logic       br,
      input hz_cause_e  e4,  input hz_cause_e  e1
   );
      exp_t e;
      @(posedge clk);
      #1;
      rst                = r;
      hz.ID_rs1          = rs1;
      hz.ID_rs2          = rs2;
      hz.ID_use_rs1      = u1;
      hz.ID_use_rs2      = u2;
      hz.EX_RdAddr       = rd;
      hz.EX_MemRead      = mr;
      hz.EX_RegWrite     = rw;
      hz.EX_md_start     = md;
      hz.EX_branch_taken = br;
      if (!r) begin
         modelCnt4 = 4'd0;
         modelCnt1 = 32'd0;
      end
      e.idx   = vecIdx;
      e.ctrl4 = expCtrl(e4);
      e.ctrl1 = expCtrl(e1);
      e.cnt4  = modelCnt4;
      e.cnt1  = modelCnt1;
      sb.push_back(e);
      if (r && !e.ctrl4[5] && modelCnt4 != 4'hF)        modelCnt4 = modelCnt4 + 4'd1;
      if (r && !e.ctrl1[5] && modelCnt1 != 32'hFFFFFFFF) modelCnt1 = modelCnt1 + 32'd1;
      vecIdx++;
   endtask

   task automatic checkOutput(input exp_t e);
      logic [5:0] got4;
      logic [5:0] got1;
      got4 = {hz.PC_write, hz.IFID_write, hz.IDEX_write,
              hz.IFID_flush, hz.IDEX_flush, hz.EXMEM_bubble};
      got1 = {hz1.PC_write, hz1.IFID_write, hz1.IDEX_write,
              hz1.IFID_flush, hz1.IDEX_flush, hz1.EXMEM_bubble};
      total++;
      if (got4 !== e.ctrl4) begin
         bad++;
         $display("[TB] FAIL ctrl_lat4 vec=%0d got=%b want=%b", e.idx, got4, e.ctrl4);
      end
      total++;
      if (got1 !== e.ctrl1) begin
         bad++;
         $display("[TB] FAIL ctrl_lat1 vec=%0d got=%b want=%b", e.idx, got1, e.ctrl1);
      end
`ifdef HAZARD_STALL_CNT_EN
      total++;
      if (stallCnt4 !== e.cnt4) begin
         bad++;
         $display("[TB] FAIL stall_cnt_w4 vec=%0d got=%0d want=%0d", e.idx, stallCnt4, e.cnt4);
      end
      total++;
      if (stallCnt1 !== e.cnt1) begin
         bad++;
         $display("[TB] FAIL stall_cnt_w32 vec=%0d got=%0d want=%0d", e.idx, stallCnt1, e.cnt1);
      end
`endif
   endtask

   // Monitor: the controls are combinational, so one response is due every cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput(e);
         end
      end
   end

   initial begin
      total     = 0;
      bad       = 0;
      vecIdx    = 0;
      modelCnt4 = 4'd0;
      modelCnt1 = 32'd0;
      rst                = 1'b0;
      hz.ID_rs1          = 5'd0;
      hz.ID_rs2          = 5'd0;
      hz.ID_use_rs1      = 1'b0;
      hz.ID_use_rs2      = 1'b0;
      hz.EX_RdAddr       = 5'd0;
      hz.EX_MemRead      = 1'b0;
      hz.EX_RegWrite     = 1'b0;
      hz.EX_md_start     = 1'b0;
      hz.EX_branch_taken = 1'b0;

      //             rst rs1 rs2 u1 u2 rd  mr rw md br  lat4           lat1
      applyStimulus(0, 0,  0,  0, 0, 0,  0, 0, 0, 0, HZ_CAUSE_NONE, HZ_CAUSE_NONE);
      applyStimulus(1, 0,  0,  0, 0, 0,  0, 0, 0, 0, HZ_CAUSE_NONE, HZ_CAUSE_NONE);
      applyStimulus(1, 5,  0,  1, 0, 5,  1, 1, 0, 0, HZ_CAUSE_LU,   HZ_CAUSE_LU);
      applyStimulus(1, 5,  0,  1, 0, 9,  0, 1, 0, 0, HZ_CAUSE_NONE, HZ_CAUSE_NONE);
      applyStimulus(1, 0,  0,  1, 0, 0,  1, 1, 0, 0, HZ_CAUSE_NONE, HZ_CAUSE_NONE);
      applyStimulus(1, 5,  0,  0, 0, 5,  1, 1, 0, 0, HZ_CAUSE_NONE, HZ_CAUSE_NONE);
      applyStimulus(1, 1,  7,  1, 1, 7,  1, 1, 0, 0, HZ_CAUSE_LU,   HZ_CAUSE_LU);
      applyStimulus(1, 5,  0,  1, 0, 5,  1, 1, 0, 1, HZ_CAUSE_BR,   HZ_CAUSE_BR);
      applyStimulus(1, 0,  7,  0, 1, 7,  1, 0, 0, 0, HZ_CAUSE_NONE, HZ_CAUSE_NONE);
      applyStimulus(1, 12, 3,  1, 0, 12, 1, 1, 0, 0, HZ_CAUSE_LU,   HZ_CAUSE_LU);
      // MUL/DIV at t=10: hold t..t+2, release t+3, branch at t+1 ignored.
      applyStimulus(1, 0,  0,  0, 0, 0,  0, 0, 1, 0, HZ_CAUSE_MD,   HZ_CAUSE_NONE);
      applyStimulus(1, 0,  0,  0, 0, 0,  0, 0, 1, 1, HZ_CAUSE_MD,   HZ_CAUSE_BR);
      applyStimulus(1, 3,  0,  1, 0, 3,  1, 1, 1, 0, HZ_CAUSE_MD,   HZ_CAUSE_LU);
      applyStimulus(1, 0,  0,  0, 0, 0,  0, 0, 1, 0, HZ_CAUSE_NONE, HZ_CAUSE_NONE);
      applyStimulus(1, 0,  0,  0, 0, 0,  0, 0, 0, 0, HZ_CAUSE_NONE, HZ_CAUSE_NONE);
      // Reset at t+1 of a sequence drops hold at once and forgets it.
      applyStimulus(1, 0,  0,  0, 0, 0,  0, 0, 1, 0, HZ_CAUSE_MD,   HZ_CAUSE_NONE);
      applyStimulus(0, 0,  0,  0, 0, 0,  0, 0, 0, 0, HZ_CAUSE_NONE, HZ_CAUSE_NONE);
      applyStimulus(1, 0,  0,  0, 0, 0,  0, 0, 0, 0, HZ_CAUSE_NONE, HZ_CAUSE_NONE);
      applyStimulus(1, 0,  0,  0, 0, 0,  0, 0, 1, 0, HZ_CAUSE_MD,   HZ_CAUSE_NONE);
      applyStimulus(1, 0,  0,  0, 0, 0,  0, 0, 1, 0, HZ_CAUSE_MD,   HZ_CAUSE_NONE);
      applyStimulus(1, 0,  0,  0, 0, 0,  0, 0, 1, 0, HZ_CAUSE_MD,   HZ_CAUSE_NONE);
      applyStimulus(1, 0,  0,  0, 0, 0,  0, 0, 1, 0, HZ_CAUSE_NONE, HZ_CAUSE_NONE);
      // Back-to-back MUL/DIV: a new one right after release starts afresh.
      applyStimulus(1, 0,  0,  0, 0, 0,  0, 0, 1, 0, HZ_CAUSE_MD,   HZ_CAUSE_NONE);
      applyStimulus(1, 0,  0,  0, 0, 0,  0, 0, 1, 0, HZ_CAUSE_MD,   HZ_CAUSE_NONE);
      applyStimulus(1, 0,  0,  0, 0, 0,  0, 0, 1, 0, HZ_CAUSE_MD,   HZ_CAUSE_NONE);
      applyStimulus(1, 0,  0,  0, 0, 0,  0, 0, 0, 0, HZ_CAUSE_NONE, HZ_CAUSE_NONE);
      // Twenty further stalls drive the 4-bit counter into saturation.
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1, 6, 0, 1, 0, 6, 1, 1, 0, 0, HZ_CAUSE_LU, HZ_CAUSE_LU);
      end
      applyStimulus(1, 0,  0,  0, 0, 0,  0, 0, 0, 0, HZ_CAUSE_NONE, HZ_CAUSE_NONE);
      applyStimulus(1, 0,  0,  0, 0, 0,  0, 0, 0, 0, HZ_CAUSE_NONE, HZ_CAUSE_NONE);

      for (int i = 0; i < 8 && sb.size() != 0; i++) @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         total++;
         bad++;
         $display("[TB] FAIL drain pending=%0d want=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage RISC-V core: the producer-side counterpart to operand forwarding. It detects hazards that forwarding cannot resolve and converts them into stall, hold and flush controls for the IF/ID, ID/EX and EX/MEM registers and the PC. Three hazards are handled:
- load-use stalls;
- taken-branch flushes;
- multi-cycle MUL/DIV occupancy of EX, tracked by a small state machine.

## Interface
Parameters:
- MD_LAT, 4, total cycles a MUL/DIV instruction occupies EX (legal range 1–16)
- CNT_W, 32, width of stall counter (only with macro)

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- ID_rs1, ID_rs2  in  5  source register addresses of the instruction in ID
- ID_use_rs1, ID_use_rs2  in  1  instruction in ID actually reads rs1/rs2
- EX_RdAddr  in  5  destination register of the instruction in EX
- EX_MemRead, EX_RegWrite  in  1  instruction in EX is a load / writes a register
- EX_md_start  in  1  instruction in EX is MUL/DIV; level, stays high while held
- EX_branch_taken  in  1  branch/jump resolved taken in EX
- PC_write  out  1  PC update enable
- IFID_write, IDEX_write  out  1  pipeline register load enables
- IFID_flush, IDEX_flush  out  1  insert bubble (clear to NOP) into register
- EXMEM_bubble  out  1  EX result invalid this cycle; EX/MEM loads NOP
- stall_cnt  out  CNT_W  stall cycle count (macro only)

## Operation
- Signal `hold`:
  - IDLE: hold = EX_md_start && MD_LAT>1.
  - BUSY: hold = (cnt != 0).
- Signal `lu` (load-use) = EX_MemRead && EX_RegWrite && EX_RdAddr!=0 && ((ID_use_rs1 && ID_rs1==EX_RdAddr) || (ID_use_rs2 && ID_rs2==EX_RdAddr)).
- Priority is hold > branch > lu > none.
  - hold: PC_write=0, IFID_write=0, IDEX_write=0, IFID_flush=0, IDEX_flush=0, EXMEM_bubble=1. EX_branch_taken and lu are ignored.
  - branch: PC_write=1, IFID_write=1, IDEX_write=1, IFID_flush=1, IDEX_flush=1, EXMEM_bubble=0. A concurrent lu is dropped because the ID instruction is discarded.
  - lu: PC_write=0, IFID_write=0, IDEX_write=1, IDEX_flush=1, IFID_flush=0, EXMEM_bubble=0.
  - none: all write enables 1, all flushes/bubble 0.
- MUL/DIV FSM, states IDLE and BUSY, with a 4-bit counter cnt:
  - IDLE → BUSY when EX_md_start && MD_LAT>1; cnt loads MD_LAT-2.
  - BUSY with cnt!=0: cnt decrements.
  - BUSY with cnt==0: → IDLE (release cycle, hold=0).
  - EX_md_start is ignored in BUSY. A new MUL/DIV entering EX in the cycle after release starts a fresh sequence.
- All outputs are combinational from inputs and state. No arithmetic except the cnt decrement, which never wraps.

## Timing
- Reset (rst=0): state=IDLE, cnt=0, stall_cnt=0, asynchronously. Outputs then follow the IDLE equations.
- Reset during BUSY drops hold in the same cycle. Nothing is remembered after reset.
- load-use: exactly one stall cycle. The next cycle the load is in MEM and lu is false.
- MUL/DIV starting in EX at cycle t: hold=1 in cycles t … t+MD_LAT-2, hold=0 at t+MD_LAT-1. MD_LAT=1 never holds.

## Configuration
- HAZARD_STALL_CNT_EN defined:
  - stall_cnt port and register exist.
  - stall_cnt increments by 1 on every clock edge where PC_write==0, and saturates at all-ones.
  - Branch flush cycles are not counted.
- Not defined: port and counter are absent; all other behaviour is identical.

## Structure
- Shared `parameter_define.sv` gains:
  - FSM state encodings HZ_IDLE/HZ_BUSY;
  - the default MD_LAT value;
  - the hazard-cause encoding (NONE, LU, BR, MD) for debug visibility.
- One natural sub-module, `md_busy_fsm`: FSM plus cnt, output `hold`. The top-level hazard_ctrl holds the priority logic and the optional counter.

## Test plan
- Load-use: EX_MemRead=1, EX_RegWrite=1, EX_RdAddr=5, ID_rs1=5, ID_use_rs1=1 → one cycle with PC_write=0, IFID_write=0, IDEX_flush=1. Repeat with EX_RdAddr=0 or ID_use_rs1=0 → no stall.
- Branch vs load-use: lu conditions plus EX_branch_taken=1 → IFID_flush=1, IDEX_flush=1, PC_write=1.
- MUL/DIV, MD_LAT=4: EX_md_start high from cycle t → hold/EXMEM_bubble=1 at t, t+1, t+2 and 0 at t+3. EX_branch_taken=1 at t+1 → ignored.
- Reset at t+1 of a MUL/DIV sequence → hold=0 immediately; after release, IDLE with stall_cnt=0. MD_LAT=1 → no hold ever.
- Counter (macro on):
  - 3 load-use stalls plus one MD_LAT=4 MUL/DIV → stall_cnt=6.
  - CNT_W=4 with 20 stall cycles → stall_cnt=15.
- Macro off: the same stimulus gives identical control outputs.
